tinyalu_cmd_driver: RTL and testbench

- Upstream stage for the TinyALU. Buffers operand/opcode commands from a requester in a small FIFO and issues them one at a time on the ALU start/op/A/B/done handshake.
- Honours the ALU protocol: operands are held stable from start until done, and start is dropped the cycle after done.
- Captures each 16-bit result into a response register with valid/ready backpressure.
- Flags commands that never complete (timeout) and illegal opcodes.

---
 rtl/tinyalu_cmd_driver.sv | 171 +++++++++++++++++
 tb/tb_tinyalu_cmd_driver.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyalu_cmd_driver.sv
// Command driver for the TinyALU: queues {op,A,B} commands, issues them one at a
// time on the start/done handshake and returns results through a response register.
module tinyalu_cmd_driver #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        start,
    output logic [2:0]  op,
    output logic [7:0]  A,
    output logic [7:0]  B,
    input  logic        done,
    input  logic [15:0] result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [2:0]  rsp_op,
    output logic [15:0] rsp_result,
    output logic        timeout_err,
    output logic        illegal_err,
    output logic [1:0]  dbg_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [18:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          ready_en;
    logic          push, pop, empty, full;
    logic [2:0]    head_op;
    logic [7:0]    head_a, head_b;
    logic [CW-1:0] tmo_cnt;
    logic          issue, capture, abandon, drop_illegal;

    // Both cmd and rsp channels transfer on a rising edge where valid && ready;
    // a producer holds valid and its payload stable until that edge.
    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign cmd_ready = ready_en && !full;
    assign push      = cmd_valid && cmd_ready;
    assign {head_op, head_a, head_b} = mem[rd_ptr];
    assign start     = (state_q == ISSUE);
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // No-ops and illegal opcodes are retired from IDLE without touching the ALU;
    // a legal command waits until the response slot is empty or being emptied.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        issue        = 1'b0;
        capture      = 1'b0;
        abandon      = 1'b0;
        drop_illegal = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (head_op == 3'b000) begin
                        pop = 1'b1;
                    end else if (head_op >= 3'b101) begin
                        pop          = 1'b1;
                        drop_illegal = 1'b1;
                    end else if (!rsp_valid || rsp_ready) begin
                        pop     = 1'b1;
                        issue   = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (done) begin
                    capture = 1'b1;
                    state_d = GAP;
                end else if (tmo_cnt == TO_LAST) begin
                    abandon = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            op          <= '0;
            A           <= '0;
            B           <= '0;
            tmo_cnt     <= '0;
            rsp_valid   <= 1'b0;
            rsp_op      <= '0;
            rsp_result  <= '0;
            timeout_err <= 1'b0;
            illegal_err <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Operands only load on issue, so they stay put through ISSUE and
            // keep their last values while start is low.
            if (issue) begin
                op      <= head_op;
                A       <= head_a;
                B       <= head_b;
                tmo_cnt <= '0;
            end else if (state_q == ISSUE) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (capture) begin
                rsp_valid  <= 1'b1;
                rsp_op     <= op;
                rsp_result <= result;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            timeout_err <= abandon;
            illegal_err <= drop_illegal;
        end
    end

endmodule

// File: tb/tb_tinyalu_cmd_driver.sv
// Directed bench for tinyalu_cmd_driver: a simple ALU responder, a protocol
// monitor that records responses, and a linear sequence of checked steps.
module tb_tinyalu_cmd_driver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        done_w;
    logic [15:0] alu_res = '0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_op;
    logic [15:0] rsp_result;
    logic        timeout_err;
    logic        illegal_err;
    logic [1:0]  dbg_state;

    logic alu_en    = 1'b0;
    logic alu_done  = 1'b0;
    logic spur_done = 1'b0;
    int   alu_cnt   = 0;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    int          n_starts    = 0;
    int          n_timeout   = 0;
    int          n_illegal   = 0;
    int          hi_run      = 0;
    int          hi_run_last = 0;
    int          low_run     = 0;
    logic        prev_start  = 1'b0;
    logic        seen_start  = 1'b0;
    logic [18:0] prev_opab   = '0;
    logic [18:0] got_q[$];

    assign done_w = alu_done | spur_done;

    always #5 clk = ~clk;

    tinyalu_cmd_driver #(.DEPTH(4), .TIMEOUT(64)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .done        (done_w),
        .result      (alu_res),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_op      (rsp_op),
        .rsp_result  (rsp_result),
        .timeout_err (timeout_err),
        .illegal_err (illegal_err),
        .dbg_state   (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ALU responder: done three cycles after start rises, with the real result.
    always begin
        @(posedge clk);
        #2;
        if (alu_en && start) begin
            alu_cnt++;
            if (alu_cnt == 3) begin
                alu_done = 1'b1;
                case (op)
                    3'b001:  alu_res = {8'h00, A} + {8'h00, B};
                    3'b010:  alu_res = {8'h00, A & B};
                    3'b011:  alu_res = {8'h00, A ^ B};
                    3'b100:  alu_res = 16'(A) * 16'(B);
                    default: alu_res = 16'hDEAD;
                endcase
            end else begin
                alu_done = 1'b0;
            end
        end else begin
            alu_cnt  = 0;
            alu_done = 1'b0;
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (!reset_n) begin
            prev_start = 1'b0;
            seen_start = 1'b0;
            hi_run     = 0;
            low_run    = 0;
        end else begin
            if (start) begin
                if (!prev_start) begin
                    n_starts++;
                    if (seen_start) chk("start_gap", 32'(low_run >= 2), 1);
                    seen_start = 1'b1;
                    hi_run     = 0;
                end else begin
                    chk("opab_stable", {13'd0, op, A, B}, {13'd0, prev_opab});
                end
                hi_run++;
                prev_opab = {op, A, B};
            end else begin
                if (prev_start) begin
                    hi_run_last = hi_run;
                    low_run     = 0;
                end
                low_run++;
            end
            prev_start = start;
            if (timeout_err) n_timeout++;
            if (illegal_err) n_illegal++;
            if (rsp_valid && rsp_ready) got_q.push_back({rsp_op, rsp_result});
        end
    end

    task automatic push(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = o;
        cmd_a     = a;
        cmd_b     = b;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_q(input string tag, input int want);
        int n = 0;
        while (got_q.size() < want && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, got_q.size(), want);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int t0;
        int i0;
        int n;
        logic [18:0] exp_mul [5];
        exp_mul = '{{3'b100, 16'hFE01}, {3'b100, 16'h0006}, {3'b100, 16'h0100},
                    {3'b100, 16'h006E}, {3'b100, 16'h00FE}};

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        alu_en    = 1'b1;

        // reset state and first-clock cmd_ready
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {cmd_ready, start, rsp_valid, timeout_err, illegal_err}, 0);
        chk("rst_opab", {op, A, B}, 0);
        chk("rst_rsp", {rsp_op, rsp_result}, 0);
        chk("rst_state", dbg_state, 0);
        reset_n = 1'b1;
        #1;
        chk("ready_at_release", cmd_ready, 0);
        @(negedge clk);
        chk("ready_first_clk", cmd_ready, 1);

        // single add 12+34
        push(3'b001, 8'h12, 8'h34);
        n = 0;
        while (done_w !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("add_done_seen", done_w, 1);
        chk("add_rsp_not_yet", rsp_valid, 0);
        @(negedge clk);
        chk("add_rsp", {rsp_valid, rsp_op, rsp_result}, {1'b1, 3'b001, 16'h0046});
        chk("add_start_dropped", start, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("add_rsp_taken", rsp_valid, 0);
        chk("add_start_cycles", hi_run_last, 3);
        chk("add_opab_retained", {op, A, B}, {3'b001, 8'h12, 8'h34});
        chk("add_rsp_count", got_q.size(), 1);

        // five back-to-back multiplies fill the FIFO
        repeat (3) @(negedge clk);
        got_q.delete();
        rsp_ready = 1'b1;
        push(3'b100, 8'hFF, 8'hFF);
        push(3'b100, 8'h02, 8'h03);
        push(3'b100, 8'h10, 8'h10);
        push(3'b100, 8'h0A, 8'h0B);
        push(3'b100, 8'h7F, 8'h02);
        chk("full_ready_low", cmd_ready, 0);
        @(negedge clk);
        chk("full_ready_still_low", cmd_ready, 0);
        @(negedge clk);
        chk("ready_after_pop", cmd_ready, 1);
        wait_q("mul_rsp_count", 5);
        for (int i = 0; i < 5; i++) begin
            chk("mul_rsp", {13'd0, got_q[i]}, {13'd0, exp_mul[i]});
        end

        // backpressure holds the next issue
        repeat (4) @(negedge clk);
        rsp_ready = 1'b0;
        got_q.delete();
        s0 = n_starts;
        push(3'b001, 8'h01, 8'h02);
        push(3'b010, 8'h0F, 8'h3C);
        push(3'b011, 8'h55, 8'hFF);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        chk("bp_starts", n_starts - s0, 1);
        chk("bp_held_rsp", {rsp_valid, rsp_op, rsp_result}, {1'b1, 3'b001, 16'h0003});
        chk("bp_start_low", start, 0);
        rsp_ready = 1'b1;
        wait_q("bp_rsp_count", 3);
        chk("bp_rsp0", {13'd0, got_q[0]}, {13'd0, 3'b001, 16'h0003});
        chk("bp_rsp1", {13'd0, got_q[1]}, {13'd0, 3'b010, 16'h000C});
        chk("bp_rsp2", {13'd0, got_q[2]}, {13'd0, 3'b011, 16'h00AA});

        // no_op, illegal, then xor
        repeat (4) @(negedge clk);
        got_q.delete();
        s0 = n_starts;
        i0 = n_illegal;
        push(3'b000, 8'h11, 8'h22);
        push(3'b110, 8'h33, 8'h44);
        push(3'b011, 8'hF0, 8'h0F);
        wait_q("mix_rsp_count", 1);
        repeat (4) @(negedge clk);
        chk("mix_starts", n_starts - s0, 1);
        chk("mix_illegal_pulses", n_illegal - i0, 1);
        chk("mix_xor_rsp", {13'd0, got_q[0]}, {13'd0, 3'b011, 16'h00FF});
        chk("mix_idle", dbg_state, 0);

        // timeout, late done ignored, next command runs
        repeat (4) @(negedge clk);
        got_q.delete();
        alu_en = 1'b0;
        s0 = n_starts;
        t0 = n_timeout;
        push(3'b001, 8'h05, 8'h06);
        push(3'b001, 8'h07, 8'h08);
        n = 0;
        while (!timeout_err && n < 150) begin
            @(negedge clk);
            n++;
        end
        chk("to_pulse_seen", timeout_err, 1);
        chk("to_start_dropped", start, 0);
        alu_en    = 1'b1;
        spur_done = 1'b1;
        #2;
        chk("to_start_cycles", hi_run_last, 64);
        @(negedge clk);
        spur_done = 1'b0;
        wait_q("to_rsp_count", 1);
        repeat (6) @(negedge clk);
        chk("to_pulse_count", n_timeout - t0, 1);
        chk("to_only_one_rsp", got_q.size(), 1);
        chk("to_next_rsp", {13'd0, got_q[0]}, {13'd0, 3'b001, 16'h000F});
        chk("to_starts", n_starts - s0, 2);

        // reset in the middle of ISSUE with two entries queued
        repeat (4) @(negedge clk);
        alu_en = 1'b0;
        got_q.delete();
        push(3'b001, 8'h01, 8'h01);
        push(3'b001, 8'h02, 8'h02);
        push(3'b001, 8'h03, 8'h03);
        chk("pre_rst_start", start, 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_outs", {start, rsp_valid, cmd_ready}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        alu_en  = 1'b1;
        s0 = n_starts;
        repeat (20) @(negedge clk);
        chk("post_rst_no_start", n_starts - s0, 0);
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_idle", dbg_state, 0);
        push(3'b010, 8'hF0, 8'h3C);
        wait_q("post_rst_rsp_count", 1);
        repeat (10) @(negedge clk);
        chk("post_rst_only_new", got_q.size(), 1);
        chk("post_rst_rsp", {13'd0, got_q[0]}, {13'd0, 3'b010, 16'h0030});

        if (fail_cnt != 0) $display("comparisons not matching: %0d", fail_cnt);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
